// File: rtl/fifo_ring_pkg.sv
// Shared constants, level-width helper and error-flag payload for fifo_ring.
package fifo_ring_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_DEPTH    = 16;
  localparam int unsigned DEFAULT_AE_LEVEL = 2;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

endpackage

// File: rtl/fifo_ring_ptr.sv
// Ring pointer: advances by one per enabled cycle and wraps from DEPTH-1 to 0.
module fifo_ring_ptr #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     advance,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned PW = $clog2(DEPTH);

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      if (ptr == PW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO with occupancy flags and sticky overflow/underflow.
// Define FIFO_RING_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_ring
  import fifo_ring_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = DEFAULT_AE_LEVEL
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          pop,
  output logic [WIDTH-1:0]              data_out,
  output logic                          data_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clear_err
);

  localparam int unsigned LW = level_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  err_flags_t       err;

  // A full FIFO may accept a push only when a pop frees a slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_LEVEL));
  assign almost_empty = (level <= LW'(AE_LEVEL));
  assign overflow     = err.overflow;
  assign underflow    = err.underflow;

  fifo_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (push_ok),
    .ptr     (wr_ptr)
  );

  fifo_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clock   (clock),
    .reset   (reset),
    .advance (pop_ok),
    .ptr     (rd_ptr)
  );

  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level <= '0;
    end else if (push_ok && !pop_ok) begin
      level <= level + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level <= level - LW'(1);
    end
  end

  // A new error event in the same cycle takes priority over clear_err.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= '0;
    end else begin
      err.overflow  <= (push && full && !pop) || (err.overflow  && !clear_err);
      err.underflow <= (pop && empty)         || (err.underflow && !clear_err);
    end
  end

`ifdef FIFO_RING_FWFT_EN
  always_comb begin
    data_out   = '0;
    data_valid = !empty;
    if (!empty) data_out = mem[rd_ptr];
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (pop_ok) begin
      data_out   <= mem[rd_ptr];
      data_valid <= 1'b1;
    end else begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/fifo_ring.md
FIFO_RING -- requirements
Module: fifo_ring

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, storage entries (>=2, any integer, not restricted to powers of two).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 push  in  1  write request.
REQ-008 data_in  in  WIDTH  word written on accepted push.
REQ-009 pop  in  1  read request.
REQ-010 data_out  out  WIDTH  read word.
REQ-011 data_valid  out  1  data_out holds a popped/head word.
REQ-012 full, empty  out  1 each  level==DEPTH, level==0.
REQ-013 almost_full, almost_empty  out  1 each  level>=AF_LEVEL, level<=AE_LEVEL.
REQ-014 level  out  $clog2(DEPTH+1)  current occupancy.
REQ-015 overflow, underflow  out  1 each  sticky error flags.
REQ-016 clear_err  in  1  clears sticky error flags.

Function
REQ-017 Storage: circular buffer, read/write pointers, each wraps from DEPTH-1 to 0; no data shifting.
REQ-018 Pop accepted iff pop && !empty; push accepted iff push && (!full || pop accepted in the same cycle).
REQ-019 Push and pop accepted together: both pointers advance, level unchanged; legal when full (slot freed and rewritten in that cycle) and never when empty (push alone accepted, no bypass).
REQ-020 level += 1 on push only, -= 1 on pop only; full/empty/almost flags are combinational from level.
REQ-021 Rejected push (push && full && !pop) sets overflow; pop while empty sets underflow; no state change otherwise.
REQ-022 clear_err clears both flags next edge; a set event in the same cycle wins over clear.
REQ-023 Registered read mode: pop accepted at edge N -> data_out = head word, data_valid=1 for the cycle after N; otherwise data_out=0, data_valid=0.
REQ-024 Data order strictly FIFO across any number of pointer wraps.

Reset
REQ-025 reset at any edge, including mid-burst: pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0, data_valid=0; push/pop ignored that cycle.
REQ-026 Storage contents need not be cleared.

Configuration
REQ-027 Macro FIFO_RING_FWFT_EN selects first-word-fall-through.
REQ-028 Defined: data_out = head word combinationally, data_valid = !empty; pop consumes the displayed word; zero read latency; data_out=0 when empty.
REQ-029 Undefined: registered read per REQ-023 (one-cycle latency).

Structure
REQ-030 Package fifo_ring_pkg holds default parameter constants, level-width function and an error-flag struct typedef {overflow, underflow}.
REQ-031 Sub-module fifo_ring_ptr: wrap-at-DEPTH pointer counter with advance input and synchronous reset, instantiated twice.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 Push 0x11,0x22,0x33,0x44 -> full=1, level=4, almost_full asserted at level 3; 5th push 0x55 -> overflow=1, level stays 4.
REQ-033 Pop x4 after REQ-032 -> 0x11,0x22,0x33,0x44 in order (registered: one cycle later each); 5th pop -> underflow=1, data_valid=0.
REQ-034 Full FIFO, push 0xAA with pop same cycle -> pop returns 0x11, level=4, 0xAA emerges last; 10 such cycles verify wrap.
REQ-035 Empty FIFO, push 0x5A with pop -> underflow=1, level=1, no word returned that cycle; later pop returns 0x5A.
REQ-036 reset mid-burst at level 3 -> next cycle level=0, empty=1, flags=0; clear_err with concurrent overflow event -> overflow stays 1.
REQ-037 Run REQ-032..034 with FIFO_RING_FWFT_EN defined and undefined; check latency 0 vs 1.
